bus_deserializer: RTL and testbench
===================================

Name: bus_deserializer

Overview:
- Bus-side receiver that pairs with the wide-to-bus serializer. It accepts owidth-bit beats, each carrying a last flag, and reassembles them into width-bit messages.
- Completed messages are buffered in a 2-entry output queue and presented with first/deq semantics.
- It sits between a narrow bus link and wide message consumers (indication/request dispatch).

Parameters:
- owidth, 32: beat width in bits.
- width, 128: message width in bits; must be an integer multiple of owidth.
- DEPTH, 2: output queue entries; fixed at 2 and not user-tunable.

Ports:
- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  reset, asynchronous assert, active low.
- in_enq__ENA  in  1  beat valid/strobe.
- in_enq_v  in  owidth  beat data.
- in_enq_last  in  1  beat is final beat of its message.
- in_enq__RDY  out  1  beat can be accepted.
- out_first  out  width  head message data.
- out_first_len  out  LW  head message beat count, 1..N; LW = $clog2(N)+1, N = width/owidth.
- out_first__RDY  out  1  head message valid.
- out_deq__ENA  in  1  pop head.
- out_deq__RDY  out  1  equals out_first__RDY.
- clear__ENA  in  1  flush partial assembly and queue.
- clear__RDY  out  1  constant 1.

Behaviour:
- Reset (nRST low, asynchronous):
  - beat index idx=0, assembly register=0, queue count=0, queue pointers=0.
  - Outputs: out_first__RDY=0, out_first=0, out_first_len=0, in_enq__RDY=1.
- Callers must assert __ENA only when the matching __RDY is high.
- Beat ordering is MSB first:
  - Beat k writes bits [width-1-k*owidth -: owidth].
  - Unwritten low slices read 0.
- Assembly states, encoded by idx:
  - IDLE (idx=0): on enq, write slice 0 and clear the rest of the assembly register.
  - COLLECT (0<idx<N): on enq, write slice idx.
- A beat completes the message when in_enq_last=1 OR idx==N-1.
  - On completion: push {assembled data including this beat, len=idx+1} into the queue; idx->0.
  - Otherwise: idx->idx+1.
- in_enq__RDY = (count < DEPTH). This uses registered count only; a same-cycle deq does not raise RDY, so there is no combinational path deq->enq RDY.
- Latency: a completing beat at edge t makes the message visible on out_first/out_first__RDY after edge t (registered, 1 cycle).
- Queue:
  - out_first and out_first_len show the head entry.
  - deq pops it.
  - Simultaneous push and pop with count=1: count stays 1 and the new entry becomes head on the next cycle.
  - Push with count=0 and pop with count=0 cannot occur together (deq is gated by RDY).
- clear__ENA, highest priority:
  - Next cycle: idx=0, count=0, assembly zeroed.
  - A same-cycle in_enq or out_deq is discarded and does not take effect.
- Non-completing beats are accepted while count==DEPTH? No. RDY is global, and a full queue stalls all beats. This is kept deliberately simple.
- Reset mid-message discards the partial assembly; the next beat starts at slice 0.

Optional Feature:
- Macro: BUS_DESERIALIZER_PROTOCOL_CHECK_EN.
- Enabled:
  - Adds output port proto_err (1 bit, sticky) and output err_count (8 bits, saturating at 255).
  - An error is a completion at idx==N-1 with in_enq_last=0 (overlong message truncated).
  - The message is still pushed with len=N.
  - clear__ENA zeroes both; reset zeroes both.
- Disabled: ports absent; a completion at N beats is silent.

Decomposition:
- Shared package bus_adapter_pkg holds:
  - localparam functions for N and LW.
  - typedef msg_entry_t {logic [width-1:0] data; logic [LW-1:0] len}.
  - The beat-slice index helper.
- One natural sub-module, bus_msg_queue: a 2-entry first/deq FIFO of msg_entry_t with clear. The top handles only assembly and guards.

Test Plan:
1. Four beats (idx 0-3) 0xAAAA0001, 0xBBBB0002, 0xCCCC0003, 0xDDDD0004 with last on beat 3 -> next cycle out_first = 0xAAAA0001_BBBB0002_CCCC0003_DDDD0004, len=4, out_first__RDY=1.
2. Short message: beats 0x11111111, then 0x22222222 with last -> out_first = 0x11111111_22222222_00000000_00000000, len=2.
3. Three single-beat messages with no deq -> first two queued; in_enq__RDY=0 with count=2; third is accepted only after a deq, and the order is preserved.
4. Clear after 2 beats of a partial message, with an enq asserted in the same cycle -> queue empty, idx=0; the next 4-beat message assembles from slice 0 with no leftover data.
5. Assert nRST low mid-cycle during beat 2 -> outputs go to reset values immediately (asynchronous, not waiting for CLK); after release, a fresh message assembles correctly.
6. (BUS_DESERIALIZER_PROTOCOL_CHECK_EN) Four beats with no last -> message pushed with len=4, proto_err=1, err_count=1; a following clear -> both 0.

Source files
------------

// File: rtl/bus_adapter_pkg.sv
// rtl/bus_adapter_pkg.sv - shared sizing helpers and message entry type for the bus adapters
package bus_adapter_pkg;

    localparam int DEF_OWIDTH = 32;
    localparam int DEF_WIDTH  = 128;
    localparam int DEPTH      = 2;

    function automatic int calc_n(input int w, input int ow);
        return w / ow;
    endfunction

    function automatic int calc_lw(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int DEF_N  = calc_n(DEF_WIDTH, DEF_OWIDTH);
    localparam int DEF_LW = calc_lw(DEF_N);

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_LW-1:0]    len;
    } msg_entry_t;

    // Beats arrive MSB first: beat k occupies the k-th slice counted from the top.
    function automatic int slice_lo(input int idx, input int w, input int ow);
        return w - ow * (idx + 1);
    endfunction

endpackage

// File: rtl/bus_msg_queue.sv
// rtl/bus_msg_queue.sv - two-entry first/deq message FIFO with synchronous clear
module bus_msg_queue
    import bus_adapter_pkg::*;
#(
    parameter type entry_t = msg_entry_t
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   clear,
    input  logic   enq,
    input  entry_t enq_data,
    output logic   enq_rdy,
    input  logic   deq,
    output entry_t first,
    output logic   first_valid
);

    entry_t     mem_q [DEPTH];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign do_push     = enq && (count_q != 2'(DEPTH));
    assign do_pop      = deq && (count_q != 2'd0);
    assign enq_rdy     = (count_q != 2'(DEPTH));
    assign first_valid = (count_q != 2'd0);
    assign first       = first_valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: it is only visible through first while count is nonzero.
    always_ff @(posedge CLK) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= enq_data;
    end

endmodule

// File: rtl/bus_deserializer.sv
// rtl/bus_deserializer.sv - reassembles owidth beats into width messages; optional BUS_DESERIALIZER_PROTOCOL_CHECK_EN
module bus_deserializer
    import bus_adapter_pkg::*;
#(
    parameter  int owidth = DEF_OWIDTH,
    parameter  int width  = DEF_WIDTH,
    localparam int N      = calc_n(width, owidth),
    localparam int LW     = calc_lw(N)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_enq__ENA,
    input  logic [owidth-1:0] in_enq_v,
    input  logic              in_enq_last,
    output logic              in_enq__RDY,
    output logic [width-1:0]  out_first,
    output logic [LW-1:0]     out_first_len,
    output logic              out_first__RDY,
    input  logic              out_deq__ENA,
    output logic              out_deq__RDY,
    input  logic              clear__ENA,
    output logic              clear__RDY
`ifdef BUS_DESERIALIZER_PROTOCOL_CHECK_EN
   ,output logic              proto_err,
    output logic [7:0]        err_count
`endif
);

    typedef struct packed {
        logic [width-1:0] data;
        logic [LW-1:0]    len;
    } entry_t;

    logic [LW-1:0]    idx_q, idx_d;
    logic [width-1:0] asm_q, asm_d;
    logic             push;
    logic             complete;
    entry_t           push_entry;
    entry_t           head;

    always_comb begin
        asm_d    = asm_q;
        idx_d    = idx_q;
        push     = 1'b0;
        complete = 1'b0;
        if (clear__ENA) begin
            asm_d = '0;
            idx_d = '0;
        end else if (in_enq__ENA) begin
            complete = in_enq_last || (idx_q == LW'(N - 1));
            if (idx_q == '0) asm_d = '0;
            asm_d[slice_lo(int'(idx_q), width, owidth) +: owidth] = in_enq_v;
            push  = complete;
            idx_d = complete ? '0 : idx_q + LW'(1);
        end
    end

    assign push_entry.data = asm_d;
    assign push_entry.len  = idx_q + LW'(1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

    bus_msg_queue #(.entry_t(entry_t)) u_queue (
        .CLK         (CLK),
        .nRST        (nRST),
        .clear       (clear__ENA),
        .enq         (push),
        .enq_data    (push_entry),
        .enq_rdy     (in_enq__RDY),
        .deq         (out_deq__ENA && !clear__ENA),
        .first       (head),
        .first_valid (out_first__RDY)
    );

    assign out_first     = head.data;
    assign out_first_len = head.len;
    assign out_deq__RDY  = out_first__RDY;
    assign clear__RDY    = 1'b1;

`ifdef BUS_DESERIALIZER_PROTOCOL_CHECK_EN
    logic       proto_err_q;
    logic [7:0] err_count_q;
    logic       overlong;

    // Filling the last slice without a last flag truncates an overlong message.
    assign overlong = in_enq__ENA && !clear__ENA && !in_enq_last && (idx_q == LW'(N - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            proto_err_q <= 1'b0;
            err_count_q <= 8'd0;
        end else if (clear__ENA) begin
            proto_err_q <= 1'b0;
            err_count_q <= 8'd0;
        end else if (overlong) begin
            proto_err_q <= 1'b1;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end
    end

    assign proto_err = proto_err_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_bus_deserializer.sv
// tb/tb_bus_deserializer.sv - directed scoreboard bench for bus_deserializer
module tb_bus_deserializer;

    logic         CLK;
    logic         nRST;
    logic         in_enq__ENA;
    logic [31:0]  in_enq_v;
    logic         in_enq_last;
    logic         in_enq__RDY;
    logic [127:0] out_first;
    logic [2:0]   out_first_len;
    logic         out_first__RDY;
    logic         out_deq__ENA;
    logic         out_deq__RDY;
    logic         clear__ENA;
    logic         clear__RDY;
`ifdef BUS_DESERIALIZER_PROTOCOL_CHECK_EN
    logic         proto_err;
    logic [7:0]   err_count;
`endif

    bus_deserializer #(.owidth(32), .width(128)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .in_enq__ENA    (in_enq__ENA),
        .in_enq_v       (in_enq_v),
        .in_enq_last    (in_enq_last),
        .in_enq__RDY    (in_enq__RDY),
        .out_first      (out_first),
        .out_first_len  (out_first_len),
        .out_first__RDY (out_first__RDY),
        .out_deq__ENA   (out_deq__ENA),
        .out_deq__RDY   (out_deq__RDY),
        .clear__ENA     (clear__ENA),
        .clear__RDY     (clear__RDY)
`ifdef BUS_DESERIALIZER_PROTOCOL_CHECK_EN
       ,.proto_err      (proto_err),
        .err_count      (err_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] data;
        logic [2:0]   len;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] m_asm;
    int           m_idx;
    int           checks   = 0;
    int           failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic last);
        exp_t e;
        in_enq__ENA = 1'b1;
        in_enq_v    = v;
        in_enq_last = last;
        if (m_idx == 0) m_asm = '0;
        m_asm[127 - 32*m_idx -: 32] = v;
        if (last || m_idx == 3) begin
            e.data = m_asm;
            e.len  = 3'(m_idx + 1);
            sb.push_back(e);
            m_idx = 0;
        end else begin
            m_idx++;
        end
        step();
        in_enq__ENA = 1'b0;
        in_enq_last = 1'b0;
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        check({tag, "_rdy"}, 128'(out_first__RDY), 128'(1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 128'(0), 128'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, out_first, e.data);
            check({tag, "_len"}, 128'(out_first_len), 128'(e.len));
        end
    endtask

    task automatic deq();
        out_deq__ENA = 1'b1;
        step();
        out_deq__ENA = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; in_enq__ENA = 1'b0; in_enq_v = '0; in_enq_last = 1'b0;
        out_deq__ENA = 1'b0; clear__ENA = 1'b0;
        m_asm = '0; m_idx = 0;
        #3;
        check("rst_first_rdy", 128'(out_first__RDY), 128'(0));
        check("rst_first", out_first, 128'(0));
        check("rst_len", 128'(out_first_len), 128'(0));
        check("rst_enq_rdy", 128'(in_enq__RDY), 128'(1));
        check("rst_deq_rdy", 128'(out_deq__RDY), 128'(0));
        check("clear_rdy", 128'(clear__RDY), 128'(1));
`ifdef BUS_DESERIALIZER_PROTOCOL_CHECK_EN
        check("rst_proto_err", 128'(proto_err), 128'(0));
        check("rst_err_count", 128'(err_count), 128'(0));
`endif
        step();
        nRST = 1'b1;
        step();

        // Full four-beat message
        send(32'hAAAA0001, 1'b0);
        send(32'hBBBB0002, 1'b0);
        send(32'hCCCC0003, 1'b0);
        check("t1_not_yet", 128'(out_first__RDY), 128'(0));
        send(32'hDDDD0004, 1'b1);
        check("t1_literal", out_first, 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004);
        check("t1_deq_rdy", 128'(out_deq__RDY), 128'(1));
        check_head("t1");
        deq();
        check("t1_empty", 128'(out_first__RDY), 128'(0));

        // Short message leaves low slices zero
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b1);
        check("t2_literal", out_first, 128'h11111111_22222222_00000000_00000000);
        check_head("t2");
        deq();

        // Queue full stalls, order preserved, push+pop at count 1
        send(32'h00000A01, 1'b1);
        check("t3_rdy_one", 128'(in_enq__RDY), 128'(1));
        send(32'h00000A02, 1'b1);
        check("t3_full", 128'(in_enq__RDY), 128'(0));
        check_head("t3_m1");
        deq();
        check("t3_rdy_after_deq", 128'(in_enq__RDY), 128'(1));
        check("t3_m2_head", out_first, 128'h00000A02_00000000_00000000_00000000);
        out_deq__ENA = 1'b1;
        sb.delete(0);
        send(32'h00000A03, 1'b1);
        out_deq__ENA = 1'b0;
        check("t3_count_one", 128'(in_enq__RDY), 128'(1));
        check_head("t3_m3");
        deq();
        check("t3_drained", 128'(out_first__RDY), 128'(0));

        // Clear mid-message with queued entry and simultaneous enq
        send(32'h0000C001, 1'b1);
        send(32'h0000C002, 1'b0);
        send(32'h0000C003, 1'b0);
        clear__ENA = 1'b1; in_enq__ENA = 1'b1; in_enq_v = 32'hFFFFFFFF; in_enq_last = 1'b1;
        step();
        clear__ENA = 1'b0; in_enq__ENA = 1'b0; in_enq_last = 1'b0;
        sb.delete(); m_idx = 0;
        check("t4_empty", 128'(out_first__RDY), 128'(0));
        check("t4_enq_rdy", 128'(in_enq__RDY), 128'(1));
        step();
        check("t4_no_ghost", 128'(out_first__RDY), 128'(0));
        send(32'h44440001, 1'b0);
        send(32'h44440002, 1'b0);
        send(32'h44440003, 1'b0);
        send(32'h44440004, 1'b1);
        check("t4_literal", out_first, 128'h44440001_44440002_44440003_44440004);
        check_head("t4");
        deq();

        // Asynchronous reset mid-message
        send(32'h55550000, 1'b1);
        send(32'h55550001, 1'b0);
        send(32'h55550002, 1'b0);
        in_enq__ENA = 1'b1; in_enq_v = 32'h55550003; in_enq_last = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check("t5_async_rdy", 128'(out_first__RDY), 128'(0));
        check("t5_async_first", out_first, 128'(0));
        check("t5_async_len", 128'(out_first_len), 128'(0));
        check("t5_async_enq_rdy", 128'(in_enq__RDY), 128'(1));
        in_enq__ENA = 1'b0;
        sb.delete(); m_idx = 0;
        step();
        nRST = 1'b1;
        step();
        send(32'h66660001, 1'b0);
        send(32'h66660002, 1'b1);
        check("t5_literal", out_first, 128'h66660001_66660002_00000000_00000000);
        check_head("t5");
        deq();

`ifdef BUS_DESERIALIZER_PROTOCOL_CHECK_EN
        send(32'h77770001, 1'b0);
        send(32'h77770002, 1'b0);
        send(32'h77770003, 1'b0);
        send(32'h77770004, 1'b0);
        check_head("t6");
        check("t6_proto_err", 128'(proto_err), 128'(1));
        check("t6_err_count", 128'(err_count), 128'(1));
        clear__ENA = 1'b1;
        step();
        clear__ENA = 1'b0;
        sb.delete();
        check("t6_clr_proto_err", 128'(proto_err), 128'(0));
        check("t6_clr_err_count", 128'(err_count), 128'(0));
        check("t6_clr_empty", 128'(out_first__RDY), 128'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
